// File: rtl/bb_skid_buf_if.sv
// Valid/ready word channel used on both sides of the skid buffer.
// Signals: valid (producer -> consumer), ready (consumer -> producer), data[DW-1:0].
// Modports: master drives valid/data and reads ready; slave is the mirror.
interface bb_skid_buf_if #(
  parameter int DW = 8
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bb_skid_buf.sv
// Two-entry valid/ready register slice: cuts the ready path, full throughput, 1-cycle latency.
// Ports: clk, rst (sync, active high), flush (sync clear), s (slave channel in),
//        m (master channel out), count (occupancy 0..2). Absorbs 2 words under backpressure.
module bb_skid_buf #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  bb_skid_buf_if.slave      s,
  bb_skid_buf_if.master     m,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] main_q, main_nxt;
  logic [DW-1:0] skid_q, skid_nxt;
  logic          s_fire, m_fire;

  // Ready depends only on registered occupancy and reset, never on m.ready.
  assign s.ready = ~rst & (state != FULL);
  assign m.valid = (state != EMPTY);
  assign m.data  = main_q;
  assign count   = state;

  assign s_fire = s.valid & s.ready;
  assign m_fire = m.valid & m.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // Anything accepted in the flush cycle is dropped along with the contents.
      state_nxt = EMPTY;
      main_nxt  = RST_VAL;
      skid_nxt  = RST_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (s_fire) begin
            main_nxt  = s.data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (s_fire && m_fire) begin
            // Old word leaves this edge, new word takes its place.
            main_nxt = s.data;
          end else if (s_fire) begin
            skid_nxt  = s.data;
            state_nxt = FULL;
          end else if (m_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // s.ready is low here, so only the drain side can move.
          if (m_fire) begin
            main_nxt  = skid_q;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_skid_buf.sv
module tb_bb_skid_buf;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] count;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];

  bb_skid_buf_if #(.DW(8)) s_if ();
  bb_skid_buf_if #(.DW(8)) m_if ();

  bb_skid_buf #(.DW(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .s     (s_if),
    .m     (m_if),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then cross the edge.
  task automatic cyc(input string tag, input logic r, input logic fl, input logic sv,
                     input logic [7:0] sd, input logic mr, input logic e_sr,
                     input logic e_mv, input logic [7:0] e_md, input logic [1:0] e_cnt);
    rst = r; flush = fl; s_if.valid = sv; s_if.data = sd; m_if.ready = mr;
    @(negedge clk);
    chk({tag, ".s_ready"}, 8'(s_if.ready), 8'(e_sr));
    chk({tag, ".m_valid"}, 8'(m_if.valid), 8'(e_mv));
    chk({tag, ".m_data"},  m_if.data,      e_md);
    chk({tag, ".count"},   8'(count),      8'(e_cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    s_if.valid = 1'b1; s_if.data = 8'hAA; m_if.ready = 1'b0;
    @(posedge clk); #1;

    // Reset held with a word offered: nothing accepted.
    cyc("rst0", 1, 0, 1, 8'hAA, 0, 0, 0, 8'h00, 0);
    cyc("rst1", 1, 0, 1, 8'hAA, 0, 0, 0, 8'h00, 0);
    cyc("rel",  0, 0, 1, 8'hAA, 0, 1, 0, 8'h00, 0);
    cyc("popAA", 0, 0, 0, 8'h00, 1, 1, 1, 8'hAA, 1);
    cyc("idle0", 0, 0, 0, 8'h00, 0, 1, 0, 8'hAA, 0);

    // Streaming 0x01..0x08 at full rate.
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) cyc("str1", 0, 0, 1, 8'(i), 1, 1, 0, 8'hAA, 0);
      else        cyc($sformatf("str%0d", i), 0, 0, 1, 8'(i), 1, 1, 1, 8'(i - 1), 1);
    end
    cyc("strT", 0, 0, 0, 8'h00, 1, 1, 1, 8'h08, 1);
    cyc("strI", 0, 0, 0, 8'h00, 0, 1, 0, 8'h08, 0);

    // Backpressure: two words absorbed, third held until drain.
    cyc("bp1", 0, 0, 1, 8'h11, 0, 1, 0, 8'h08, 0);
    cyc("bp2", 0, 0, 1, 8'h22, 0, 1, 1, 8'h11, 1);
    cyc("bp3", 0, 0, 1, 8'h33, 0, 0, 1, 8'h11, 2);
    cyc("bp4", 0, 0, 1, 8'h33, 1, 0, 1, 8'h11, 2);
    cyc("bp5", 0, 0, 1, 8'h33, 1, 1, 1, 8'h22, 1);
    cyc("bp6", 0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 1);
    cyc("bp7", 0, 0, 0, 8'h00, 0, 1, 0, 8'h33, 0);

    // Flush in FULL with a word offered and downstream ready.
    cyc("fl1", 0, 0, 1, 8'h44, 0, 1, 0, 8'h33, 0);
    cyc("fl2", 0, 0, 1, 8'h55, 0, 1, 1, 8'h44, 1);
    cyc("fl3", 0, 1, 1, 8'h66, 1, 0, 1, 8'h44, 2);
    cyc("fl4", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);
    cyc("fl5", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);

    // Reset in ONE, then in FULL, then resume with 0x77.
    cyc("ro1", 0, 0, 1, 8'h5A, 0, 1, 0, 8'h00, 0);
    cyc("ro2", 1, 0, 0, 8'h00, 0, 0, 1, 8'h5A, 1);
    cyc("ro3", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
    cyc("rf1", 0, 0, 1, 8'h6A, 0, 1, 0, 8'h00, 0);
    cyc("rf2", 0, 0, 1, 8'h7A, 0, 1, 1, 8'h6A, 1);
    cyc("rf3", 1, 0, 1, 8'h8A, 1, 0, 1, 8'h6A, 2);
    cyc("rf4", 0, 0, 1, 8'h77, 0, 1, 0, 8'h00, 0);
    cyc("rf5", 0, 0, 0, 8'h00, 1, 1, 1, 8'h77, 1);
    cyc("rf6", 0, 0, 0, 8'h00, 0, 1, 0, 8'h77, 0);

    // Random traffic against a depth-2 FIFO reference.
    for (int n = 0; n < 10000; n++) begin
      logic sv, mr, sf, mf;
      logic [7:0] sd;
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      sd = 8'($urandom_range(0, 255));
      rst = 1'b0; flush = 1'b0;
      s_if.valid = sv; s_if.data = sd; m_if.ready = mr;
      @(negedge clk);
      chk("rnd.s_ready", 8'(s_if.ready), 8'(q.size() != 2));
      chk("rnd.m_valid", 8'(m_if.valid), 8'(q.size() != 0));
      chk("rnd.count",   8'(count),      8'(q.size()));
      if (q.size() != 0) chk("rnd.m_data", m_if.data, q[0]);
      // Flip m_ready mid-cycle: s_ready must not react.
      m_if.ready = ~mr;
      #1;
      chk("rnd.s_ready_indep", 8'(s_if.ready), 8'(q.size() != 2));
      m_if.ready = mr;
      #1;
      sf = sv && (q.size() < 2);
      mf = mr && (q.size() > 0);
      if (mf) void'(q.pop_front());
      if (sf) q.push_back(sd);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
